rsa_msg_framer: RTL
===================

Name: rsa_msg_framer

Overview:
- Front-end/back-end stage around the 128-bit RSA encryption core (modular-exponentiation engine with a start/done interface).
- Packs a byte stream into a 128-bit message, MSB-first, and range-checks it against modulus n.
- Re-arms the core with a reset pulse, launches it with a one-cycle start, then waits for done with a timeout.
- Returns the 128-bit ciphertext as a byte stream under valid/ready flow control.

Parameters:
- TIMEOUT, 1048576: maximum cycles spent in WAIT_DONE before aborting. Must be at least 2.
- TW, 32: width of the timeout counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_data  in  8  message byte; the first byte is the MSB.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  framer accepts a byte this cycle.
- n  in  128  RSA modulus. Must be stable from the first byte until the last output byte.
- out_data  out  8  ciphertext byte; the first byte is the MSB.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  sink accepts a byte.
- busy  out  1  a block is in flight.
- err_range  out  1  one-cycle pulse: message >= n, or n < 2.
- err_timeout  out  1  one-cycle pulse: core did not finish within TIMEOUT.
- enc_reset  out  1  reset to the encryption core.
- enc_start  out  1  start to the encryption core.
- enc_message  out  128  message to the encryption core.
- enc_done  in  1  core done. Sticky-high until the core is reset.
- enc_cipher  in  128  core ciphertext.

Behaviour:

Reset:
- Values: state=LOAD, byte count=0, timeout counter=0, out_valid=0, out_data=0, busy=0, err_range=0, err_timeout=0, enc_start=0, enc_message=0, enc_reset=1.
- A reset in any state, including mid-operation, aborts the block in flight. No error pulse is produced.

Output timing:
- All outputs except in_ready are registered.
- in_ready = (state==LOAD), decoded combinationally.

States: LOAD, CHECK, ENC_RST, ENC_START, WAIT_DONE, DRAIN.

- LOAD:
  - A transfer occurs on in_valid & in_ready: msg <= {msg[119:0], in_data}; count++.
  - Bubbles on in_valid are allowed.
  - busy goes high the cycle after the first accepted byte.
  - On the 16th transfer: go to CHECK, count=0. in_ready is low from the next cycle.
- CHECK (1 cycle):
  - Unsigned compare of msg against n.
  - If msg >= n or n < 2: err_range=1 for exactly 1 cycle, busy=0, return to LOAD. No enc_start is issued.
  - Otherwise: enc_message <= msg, go to ENC_RST.
- ENC_RST: exactly 2 cycles, then go to ENC_START.
- ENC_START (1 cycle): enc_reset=0, enc_start=1, then go to WAIT_DONE.
- WAIT_DONE:
  - enc_start=0, enc_reset=0. The timeout counter increments each cycle.
  - enc_done=1: capture enc_cipher into the output shift register, clear the counter, go to DRAIN.
  - Counter reaches TIMEOUT-1 with no done: err_timeout=1 for 1 cycle, busy=0, return to LOAD.
  - If done and timeout occur in the same cycle, done wins.
- DRAIN:
  - out_valid=1; out_data = byte [127:120] of the shift register.
  - A transfer occurs on out_valid & out_ready: shift left by 8; count++.
  - out_data is held stable while out_valid & !out_ready.
  - After the 16th transfer: out_valid=0, busy=0, go to LOAD.
  - in_ready stays low throughout; input and output never overlap.

enc_reset:
- enc_reset=1 in every state except ENC_START and WAIT_DONE.
- The core is therefore held in reset while idle, which clears its sticky done.
- enc_done is ignored outside WAIT_DONE.

Latency:
- 16th input byte accepted in cycle t:
  - CHECK at t+1.
  - enc_reset high through t+3.
  - enc_start high at t+4.
  - WAIT_DONE from t+5.
- enc_done sampled high in cycle d: out_valid=1 at d+1.

enc_message holds its value from CHECK until the next successful CHECK.

Test Plan:
1. Nominal, with a stub core. n=33, message=0x…04 (15 zero bytes then 0x04). Stub raises done 10 cycles after start with enc_cipher=0x1F.
   -> enc_message=4; enc_reset high 3 cycles; single enc_start at t+4; output is 15×0x00 then 0x1F; busy low after the last byte.
2. Range error. n=33, message=33.
   -> err_range single pulse at t+1; no enc_start; enc_reset stays 1; in_ready=1 at t+2.
   -> Repeat with n=1, message=0: same response.
3. Output backpressure. cipher=0x0102…10; out_ready toggled pseudo-randomly.
   -> Exactly 16 bytes 0x01..0x10 in order; out_data stable while stalled.
4. Timeout. TIMEOUT=64; stub never raises done.
   -> err_timeout pulse on the 64th WAIT_DONE cycle; return to LOAD; enc_reset=1; no out_valid.
5. Reset mid-DRAIN after 5 output bytes.
   -> Next cycle: out_valid=0, busy=0, enc_reset=1. After reset release: in_ready=1 and a new block completes correctly.
6. Input bubbles and a sticky done. Bytes delivered with in_valid gaps; stub holds enc_done=1 throughout LOAD.
   -> Message packs correctly; done is not acted on until WAIT_DONE; cipher is captured at the first WAIT_DONE cycle.

Source files
------------

// File: rtl/rsa_msg_framer_if.sv
// ============================================================================
//  Module      : rsa_msg_framer_if
//  Description : Byte-wide valid/ready stream used for the plaintext input
//                and ciphertext output of the RSA message framer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface rsa_msg_framer_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    // Producer side of the stream
    modport master (
        output data,
        output valid,
        input  ready
    );

    // Consumer side of the stream
    modport slave (
        input  data,
        input  valid,
        output ready
    );
endinterface

`default_nettype wire

// File: rtl/rsa_msg_framer.sv
// ============================================================================
//  Module      : rsa_msg_framer
//  Description : Packs 16 input bytes (MSB first) into a 128-bit message,
//                range-checks it against modulus n, sequences the RSA core
//                (reset, start, wait for done with timeout) and streams the
//                128-bit ciphertext back out as 16 bytes (MSB first).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rsa_msg_framer #(
    parameter int TIMEOUT = 1048576,
    parameter int TW      = 32
) (
    input  wire             clk,
    input  wire             reset,
    rsa_msg_framer_if.slave  in_s,
    rsa_msg_framer_if.master out_m,
    input  wire  [127:0]    n,
    output logic            busy,
    output logic            err_range,
    output logic            err_timeout,
    output logic            enc_reset,
    output logic            enc_start,
    output logic [127:0]    enc_message,
    input  wire             enc_done,
    input  wire  [127:0]    enc_cipher
);

    typedef enum logic [2:0] {
        LOAD      = 3'd0,
        CHECK     = 3'd1,
        ENC_RST   = 3'd2,
        ENC_START = 3'd3,
        WAIT_DONE = 3'd4,
        DRAIN     = 3'd5
    } state_t;

    // Timeout fires on the cycle the counter would step to TIMEOUT-1, so the
    // registered pulse appears on the TIMEOUT-th cycle after entering WAIT_DONE.
    localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT - 2);

    state_t         state_q,       state_d;
    logic [3:0]     count_q,       count_d;
    logic [127:0]   msg_q,         msg_d;
    logic [127:0]   shreg_q,       shreg_d;
    logic [TW-1:0]  tmo_q,         tmo_d;
    logic           out_valid_q,   out_valid_d;
    logic           busy_q,        busy_d;
    logic           err_range_q,   err_range_d;
    logic           err_timeout_q, err_timeout_d;
    logic           enc_start_q,   enc_start_d;
    logic           enc_reset_q,   enc_reset_d;
    logic [127:0]   enc_message_q, enc_message_d;

    logic           w_in_fire;
    logic           w_out_fire;
    logic [127:0]   w_msg_next;

    assign w_in_fire  = in_s.valid && (state_q == LOAD);
    assign w_out_fire = out_valid_q && out_m.ready;
    assign w_msg_next = {msg_q[119:0], in_s.data};

    // Next-state and next-output decode; every output is taken from a flop
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        msg_d         = msg_q;
        shreg_d       = shreg_q;
        tmo_d         = tmo_q;
        out_valid_d   = out_valid_q;
        err_range_d   = 1'b0;
        err_timeout_d = 1'b0;
        enc_message_d = enc_message_q;

        case (state_q)
            LOAD: begin
                if (w_in_fire) begin
                    msg_d = w_msg_next;
                    if (count_q == 4'd15) begin
                        count_d = 4'd0;
                        state_d = CHECK;
                        // Evaluated on the completed message so the flag is
                        // already registered while CHECK is the current state.
                        err_range_d = (w_msg_next >= n) || (n < 128'd2);
                    end else begin
                        count_d = count_q + 4'd1;
                    end
                end
            end
            CHECK: begin
                if (err_range_q) begin
                    state_d = LOAD;
                end else begin
                    enc_message_d = msg_q;
                    state_d       = ENC_RST;
                end
            end
            ENC_RST: begin
                // Two cycles of core reset beyond the CHECK cycle
                if (count_q == 4'd1) begin
                    count_d = 4'd0;
                    state_d = ENC_START;
                end else begin
                    count_d = count_q + 4'd1;
                end
            end
            ENC_START: begin
                tmo_d   = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (enc_done) begin
                    shreg_d     = enc_cipher;
                    tmo_d       = '0;
                    out_valid_d = 1'b1;
                    state_d     = DRAIN;
                end else if (tmo_q == C_TMO_LAST) begin
                    tmo_d         = '0;
                    err_timeout_d = 1'b1;
                    state_d       = LOAD;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            DRAIN: begin
                if (w_out_fire) begin
                    shreg_d = {shreg_q[119:0], 8'h00};
                    if (count_q == 4'd15) begin
                        count_d     = 4'd0;
                        out_valid_d = 1'b0;
                        state_d     = LOAD;
                    end else begin
                        count_d = count_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = LOAD;
                count_d = 4'd0;
            end
        endcase

        // Busy once any byte of a block is held, until the block retires
        busy_d      = (state_d != LOAD) || (count_d != 4'd0);
        enc_start_d = (state_d == ENC_START);
        enc_reset_d = !((state_d == ENC_START) || (state_d == WAIT_DONE));
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= LOAD;
            count_q       <= 4'd0;
            msg_q         <= '0;
            shreg_q       <= '0;
            tmo_q         <= '0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            err_range_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            enc_start_q   <= 1'b0;
            enc_reset_q   <= 1'b1;
            enc_message_q <= '0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            msg_q         <= msg_d;
            shreg_q       <= shreg_d;
            tmo_q         <= tmo_d;
            out_valid_q   <= out_valid_d;
            busy_q        <= busy_d;
            err_range_q   <= err_range_d;
            err_timeout_q <= err_timeout_d;
            enc_start_q   <= enc_start_d;
            enc_reset_q   <= enc_reset_d;
            enc_message_q <= enc_message_d;
        end
    end

    assign in_s.ready   = (state_q == LOAD);
    assign out_m.valid  = out_valid_q;
    assign out_m.data   = shreg_q[127:120];
    assign busy         = busy_q;
    assign err_range    = err_range_q;
    assign err_timeout  = err_timeout_q;
    assign enc_start    = enc_start_q;
    assign enc_reset    = enc_reset_q;
    assign enc_message  = enc_message_q;

endmodule

`default_nettype wire
